// File: rtl/piece_rotation_engine.sv
// Piece rotation engine: spawns tetromino bitmaps (forced, bag or LFSR pick)
// and rotates them in 90-degree clockwise steps inside a GRID x GRID box.
module piece_rotation_engine #(
    parameter int unsigned GRID      = 4,
    parameter int unsigned DIM_W     = 10,
    parameter bit          BAG_EN    = 1'b1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   spawn_req,
    input  logic                   spawn_force,
    input  logic [2:0]             force_type,
    input  logic                   rot_req,
    input  logic                   rot_dir,
    output logic                   busy,
    output logic                   done,
    output logic                   valid,
    output logic [2:0]             piece_type,
    output logic [1:0]             rot,
    output logic [GRID*GRID-1:0]   pixels,
    output logic [DIM_W-1:0]       width,
    output logic [DIM_W-1:0]       height
);

    localparam int unsigned NPIX = GRID * GRID;
    localparam int unsigned IW   = $clog2(NPIX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ROT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [15:0]      lfsr;
    logic [6:0]       mask, mask_nxt;
    logic [1:0]       steps, steps_nxt;
    logic             lat_force, lat_force_nxt;
    logic [2:0]       lat_type, lat_type_nxt;
    logic             lat_dir, lat_dir_nxt;

    logic             busy_nxt, done_nxt, valid_nxt;
    logic [2:0]       type_nxt;
    logic [1:0]       rot_nxt;
    logic [NPIX-1:0]  pixels_nxt;
    logic [DIM_W-1:0] width_nxt, height_nxt;

    logic [2:0]       cand, chosen;
    logic [6:0]       mask_after;
    logic [NPIX-1:0]  base_pix, rot_pix;
    logic [DIM_W-1:0] base_w, base_h;

    function automatic logic [IW-1:0] pix_idx(input int unsigned r, input int unsigned c);
        return IW'(r * GRID + c);
    endfunction

    // LFSR free-runs every cycle (Fibonacci, taps 16,14,13,11)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    // Type selection for the LOAD edge: forced, bag scan, or raw candidate
    always_comb begin
        logic         found;
        logic [2:0]   idx;
        logic [6:0]   mask_set;
        cand     = (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0];
        chosen   = cand;
        found    = 1'b0;
        idx      = 3'd0;
        mask_set = mask;
        if (lat_force) begin
            chosen = lat_type;
        end else if (BAG_EN) begin
            for (int unsigned k = 0; k < 7; k++) begin
                idx = 3'((int'(cand) + int'(k)) % 7);
                if (!found && !mask[idx]) begin
                    chosen = idx;
                    found  = 1'b1;
                end
            end
        end
        if (BAG_EN) begin
            mask_set = mask | (7'd1 << chosen);
        end
        mask_after = (mask_set == 7'h7F) ? 7'd0 : mask_set;
    end

    // Base (rotation 0) bitmap and bounding box of the chosen type
    always_comb begin
        base_pix = '0;
        base_w   = DIM_W'(3);
        base_h   = DIM_W'(2);
        case (chosen)
            3'd1: begin // I
                base_pix[pix_idx(0, 0)] = 1'b1;
                base_pix[pix_idx(0, 1)] = 1'b1;
                base_pix[pix_idx(0, 2)] = 1'b1;
                base_pix[pix_idx(0, 3)] = 1'b1;
                base_w = DIM_W'(4);
                base_h = DIM_W'(1);
            end
            3'd2: begin // O
                base_pix[pix_idx(0, 0)] = 1'b1;
                base_pix[pix_idx(0, 1)] = 1'b1;
                base_pix[pix_idx(1, 0)] = 1'b1;
                base_pix[pix_idx(1, 1)] = 1'b1;
                base_w = DIM_W'(2);
                base_h = DIM_W'(2);
            end
            3'd3: begin // L
                base_pix[pix_idx(0, 0)] = 1'b1;
                base_pix[pix_idx(1, 0)] = 1'b1;
                base_pix[pix_idx(2, 0)] = 1'b1;
                base_pix[pix_idx(2, 1)] = 1'b1;
                base_w = DIM_W'(2);
                base_h = DIM_W'(3);
            end
            3'd4: begin // J
                base_pix[pix_idx(0, 1)] = 1'b1;
                base_pix[pix_idx(1, 1)] = 1'b1;
                base_pix[pix_idx(2, 0)] = 1'b1;
                base_pix[pix_idx(2, 1)] = 1'b1;
                base_w = DIM_W'(2);
                base_h = DIM_W'(3);
            end
            3'd5: begin // S
                base_pix[pix_idx(0, 1)] = 1'b1;
                base_pix[pix_idx(0, 2)] = 1'b1;
                base_pix[pix_idx(1, 0)] = 1'b1;
                base_pix[pix_idx(1, 1)] = 1'b1;
            end
            3'd6: begin // Z
                base_pix[pix_idx(0, 0)] = 1'b1;
                base_pix[pix_idx(0, 1)] = 1'b1;
                base_pix[pix_idx(1, 1)] = 1'b1;
                base_pix[pix_idx(1, 2)] = 1'b1;
            end
            default: begin // T
                base_pix[pix_idx(0, 0)] = 1'b1;
                base_pix[pix_idx(0, 1)] = 1'b1;
                base_pix[pix_idx(0, 2)] = 1'b1;
                base_pix[pix_idx(1, 1)] = 1'b1;
            end
        endcase
    end

    // One clockwise step of the current bitmap, kept anchored at row 0 / col 0
    always_comb begin
        rot_pix = '0;
        for (int unsigned r = 0; r < GRID; r++) begin
            for (int unsigned c = 0; c < GRID; c++) begin
                if (r < 32'(width) && c < 32'(height)) begin
                    rot_pix[pix_idx(r, c)] = pixels[pix_idx(32'(height) - 1 - c, r)];
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; spawn has priority over rotation
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (spawn_req) begin
                    state_nxt = LOAD;
                end else if (rot_req && valid) begin
                    state_nxt = ROT;
                end
            end
            LOAD:    state_nxt = IDLE;
            ROT:     state_nxt = (steps == 2'd1) ? IDLE : ROT;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and request latches
    always_comb begin
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        valid_nxt     = valid;
        type_nxt      = piece_type;
        rot_nxt       = rot;
        pixels_nxt    = pixels;
        width_nxt     = width;
        height_nxt    = height;
        mask_nxt      = mask;
        steps_nxt     = steps;
        lat_force_nxt = lat_force;
        lat_type_nxt  = lat_type;
        lat_dir_nxt   = lat_dir;
        case (state)
            IDLE: begin
                if (spawn_req) begin
                    busy_nxt      = 1'b1;
                    lat_force_nxt = spawn_force;
                    lat_type_nxt  = (force_type == 3'd7) ? 3'd0 : force_type;
                end else if (rot_req && valid) begin
                    busy_nxt    = 1'b1;
                    lat_dir_nxt = rot_dir;
                    steps_nxt   = rot_dir ? 2'd3 : 2'd1;
                end
            end
            LOAD: begin
                busy_nxt   = 1'b0;
                done_nxt   = 1'b1;
                valid_nxt  = 1'b1;
                type_nxt   = chosen;
                rot_nxt    = 2'd0;
                pixels_nxt = base_pix;
                width_nxt  = base_w;
                height_nxt = base_h;
                mask_nxt   = mask_after;
            end
            ROT: begin
                pixels_nxt = rot_pix;
                width_nxt  = height;
                height_nxt = width;
                steps_nxt  = steps - 2'd1;
                if (steps == 2'd1) begin
                    busy_nxt = 1'b0;
                    done_nxt = 1'b1;
                    rot_nxt  = lat_dir ? (rot - 2'd1) : (rot + 2'd1);
                end
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            valid      <= 1'b0;
            piece_type <= 3'd0;
            rot        <= 2'd0;
            pixels     <= '0;
            width      <= '0;
            height     <= '0;
            mask       <= 7'd0;
            steps      <= 2'd0;
            lat_force  <= 1'b0;
            lat_type   <= 3'd0;
            lat_dir    <= 1'b0;
        end else begin
            busy       <= busy_nxt;
            done       <= done_nxt;
            valid      <= valid_nxt;
            piece_type <= type_nxt;
            rot        <= rot_nxt;
            pixels     <= pixels_nxt;
            width      <= width_nxt;
            height     <= height_nxt;
            mask       <= mask_nxt;
            steps      <= steps_nxt;
            lat_force  <= lat_force_nxt;
            lat_type   <= lat_type_nxt;
            lat_dir    <= lat_dir_nxt;
        end
    end

endmodule

// File: tb/tb_piece_rotation_engine.sv
// Self-checking bench for piece_rotation_engine with a 2D-array shape model.
module tb_piece_rotation_engine;

    localparam int unsigned GRID  = 4;
    localparam int unsigned NPIX  = GRID * GRID;
    localparam int unsigned DIM_W = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             spawn_req = 1'b0;
    logic             spawn_force = 1'b0;
    logic [2:0]       force_type = 3'd0;
    logic             rot_req = 1'b0;
    logic             rot_dir = 1'b0;
    logic             busy, done, valid;
    logic [2:0]       piece_type;
    logic [1:0]       rot;
    logic [NPIX-1:0]  pixels;
    logic [DIM_W-1:0] width, height;

    int checks = 0;
    int errors = 0;

    piece_rotation_engine #(
        .GRID(GRID), .DIM_W(DIM_W), .BAG_EN(1'b1), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .spawn_req(spawn_req), .spawn_force(spawn_force),
        .force_type(force_type), .rot_req(rot_req), .rot_dir(rot_dir),
        .busy(busy), .done(done), .valid(valid), .piece_type(piece_type), .rot(rot),
        .pixels(pixels), .width(width), .height(height)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Shapes as 4x4 character maps, top row first
    function automatic string shape_str(input int t);
        case (t)
            1:       return "XXXX............";
            2:       return "XX..XX..........";
            3:       return "X...X...XX......";
            4:       return ".X...X..XX......";
            5:       return ".XX.XX..........";
            6:       return "XX...XX.........";
            default: return "XXX..X..........";
        endcase
    endfunction

    // Expected bitmap/box after nrot clockwise quarter turns of the base shape
    task automatic model(input int t, input int nrot, output logic [NPIX-1:0] pix,
                         output int w, output int h);
        bit g[4][4];
        bit n[4][4];
        string s;
        int tmp;
        s = shape_str(t);
        w = 0;
        h = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                g[r][c] = (s[r*4+c] == "X");
                if (g[r][c]) begin
                    if (r + 1 > h) h = r + 1;
                    if (c + 1 > w) w = c + 1;
                end
            end
        end
        for (int k = 0; k < nrot; k++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    n[r][c] = 1'b0;
            for (int r = 0; r < w; r++)
                for (int c = 0; c < h; c++)
                    n[r][c] = g[h-1-c][r];
            g = n;
            tmp = w;
            w = h;
            h = tmp;
        end
        pix = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                pix[r*GRID+c] = g[r][c];
    endtask

    // Issue one request at a negedge; count busy cycles until done (bounded)
    task automatic do_op(input bit sp, input bit sf, input logic [2:0] ft, input bit rr,
                         input bit rd, output int bc, output bit gd);
        bc = 0;
        gd = 1'b0;
        spawn_req = sp;
        spawn_force = sf;
        force_type = ft;
        rot_req = rr;
        rot_dir = rd;
        @(posedge clk);
        @(negedge clk);
        spawn_req = 1'b0;
        spawn_force = 1'b0;
        rot_req = 1'b0;
        rot_dir = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                gd = 1'b1;
                break;
            end
            if (busy) bc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, valid, piece_type, rot, pixels, width, height} !== '0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got busy=%b done=%b valid=%b type=%0d rot=%0d pix=%h w=%0d h=%0d, expected all zero",
                         i, busy, done, valid, piece_type, rot, pixels, width, height);
            end
        end
    endtask

    task automatic test_spawn_t();
        int bc; bit gd;
        do_op(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, bc, gd);
        checks++;
        if (!gd || bc != 1) begin
            errors++;
            $display("FAIL spawn_t_latency: got done=%b busy_cycles=%0d, expected done=1 busy_cycles=1", gd, bc);
        end
        checks++;
        if (pixels !== 16'h0027 || width !== 10'd3 || height !== 10'd2 || rot !== 2'd0 ||
            valid !== 1'b1 || piece_type !== 3'd0) begin
            errors++;
            $display("FAIL spawn_t_shape: got pix=%h w=%0d h=%0d rot=%0d valid=%b type=%0d, expected pix=0027 w=3 h=2 rot=0 valid=1 type=0",
                     pixels, width, height, rot, valid, piece_type);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL spawn_t_done_pulse: got done=%b one cycle later, expected 0", done);
        end
    endtask

    task automatic test_rotate_cw();
        int bc; bit gd;
        do_op(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, bc, gd);
        checks++;
        if (!gd || bc != 1 || pixels !== 16'h0232 || width !== 10'd2 || height !== 10'd3 || rot !== 2'd1) begin
            errors++;
            $display("FAIL cw1: got done=%b bc=%0d pix=%h w=%0d h=%0d rot=%0d, expected done=1 bc=1 pix=0232 w=2 h=3 rot=1",
                     gd, bc, pixels, width, height, rot);
        end
        do_op(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, bc, gd);
        checks++;
        if (!gd || bc != 1 || pixels !== 16'h0072 || width !== 10'd3 || height !== 10'd2 || rot !== 2'd2) begin
            errors++;
            $display("FAIL cw2: got done=%b bc=%0d pix=%h w=%0d h=%0d rot=%0d, expected done=1 bc=1 pix=0072 w=3 h=2 rot=2",
                     gd, bc, pixels, width, height, rot);
        end
    endtask

    task automatic test_ccw_i();
        int bc; bit gd;
        do_op(1'b1, 1'b1, 3'd1, 1'b0, 1'b0, bc, gd);
        checks++;
        if (!gd || pixels !== 16'h000F || rot !== 2'd0) begin
            errors++;
            $display("FAIL spawn_i: got done=%b pix=%h rot=%0d, expected done=1 pix=000f rot=0", gd, pixels, rot);
        end
        rot_req = 1'b1;
        rot_dir = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rot_dir = 1'b0;
        bc = 0;
        gd = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                gd = 1'b1;
                break;
            end
            if (busy) bc++;
            @(negedge clk);
        end
        rot_req = 1'b0;
        checks++;
        if (!gd || bc != 3) begin
            errors++;
            $display("FAIL ccw_latency: got done=%b busy_cycles=%0d, expected done=1 busy_cycles=3", gd, bc);
        end
        checks++;
        if (pixels !== 16'h1111 || width !== 10'd1 || height !== 10'd4 || rot !== 2'd3) begin
            errors++;
            $display("FAIL ccw_shape: got pix=%h w=%0d h=%0d rot=%0d, expected pix=1111 w=1 h=4 rot=3",
                     pixels, width, height, rot);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rot !== 2'd3) begin
            errors++;
            $display("FAIL ccw_busy_drop: got busy=%b done=%b rot=%0d, expected busy=0 done=0 rot=3", busy, done, rot);
        end
    endtask

    task automatic test_random_rot();
        int bc, w, h, t, et, mrot, nops, ebc;
        bit gd, d;
        logic [NPIX-1:0] epix;
        for (int it = 0; it < 16; it++) begin
            t = $urandom_range(0, 7);
            et = (t == 7) ? 0 : t;
            do_op(1'b1, 1'b1, 3'(t), 1'b0, 1'b0, bc, gd);
            model(et, 0, epix, w, h);
            mrot = 0;
            checks++;
            if (!gd || bc != 1 || piece_type !== 3'(et) || rot !== 2'd0 || pixels !== epix ||
                width !== 10'(w) || height !== 10'(h)) begin
                errors++;
                $display("FAIL rand_spawn t=%0d: got done=%b bc=%0d type=%0d rot=%0d pix=%h w=%0d h=%0d, expected done=1 bc=1 type=%0d rot=0 pix=%h w=%0d h=%0d",
                         t, gd, bc, piece_type, rot, pixels, width, height, et, epix, w, h);
            end
            nops = $urandom_range(1, 4);
            for (int k = 0; k < nops; k++) begin
                d = 1'($urandom_range(0, 1));
                do_op(1'b0, 1'b0, 3'd0, 1'b1, d, bc, gd);
                mrot = d ? (mrot + 3) % 4 : (mrot + 1) % 4;
                ebc = d ? 3 : 1;
                model(et, mrot, epix, w, h);
                checks++;
                if (!gd || bc != ebc || rot !== 2'(mrot) || pixels !== epix ||
                    width !== 10'(w) || height !== 10'(h)) begin
                    errors++;
                    $display("FAIL rand_rot t=%0d dir=%0d: got done=%b bc=%0d rot=%0d pix=%h w=%0d h=%0d, expected done=1 bc=%0d rot=%0d pix=%h w=%0d h=%0d",
                             et, d, gd, bc, rot, pixels, width, height, ebc, mrot, epix, w, h);
                end
            end
        end
    endtask

    task automatic test_bag();
        int bc; bit gd;
        bit [6:0] seen;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int g = 0; g < 2; g++) begin
            seen = '0;
            for (int i = 0; i < 7; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                do_op(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, bc, gd);
                checks++;
                if (!gd || piece_type > 3'd6) begin
                    errors++;
                    $display("FAIL bag_spawn %0d.%0d: got done=%b type=%0d, expected done=1 type<7", g, i, gd, piece_type);
                end
                if (piece_type <= 3'd6) seen[piece_type] = 1'b1;
            end
            checks++;
            if (seen !== 7'h7F) begin
                errors++;
                $display("FAIL bag_perm group %0d: got types seen=%b, expected 1111111", g, seen);
            end
        end
        do_op(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, bc, gd);
        do_op(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, bc, gd);
        checks++;
        if (!gd || bc != 1 || rot !== 2'd0 || valid !== 1'b1) begin
            errors++;
            $display("FAIL spawn_priority: got done=%b bc=%0d rot=%0d valid=%b, expected done=1 bc=1 rot=0 valid=1",
                     gd, bc, rot, valid);
        end
    endtask

    task automatic test_mid_reset();
        int bc; bit gd;
        bit saw_done;
        do_op(1'b1, 1'b1, 3'd3, 1'b0, 1'b0, bc, gd);
        rot_req = 1'b1;
        rot_dir = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rot_req = 1'b0;
        rot_dir = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, valid, piece_type, rot, pixels, width, height} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b done=%b valid=%b type=%0d rot=%0d pix=%h w=%0d h=%0d, expected all zero",
                     busy, done, valid, piece_type, rot, pixels, width, height);
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL mid_reset_no_done: got a done pulse after aborted rotation, expected none");
        end
        rot_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0) begin
                errors++;
                $display("FAIL rot_invalid cycle %0d: got busy=%b done=%b valid=%b, expected 0 0 0", i, busy, done, valid);
            end
        end
        rot_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_spawn_t();
        test_rotate_cw();
        test_ccw_i();
        test_random_rot();
        test_bag();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
